// File: rtl/tube_pkg.sv
// tube_pkg: glyph table, FSM state and glyph-code types shared by the judge tube driver
package tube_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_J     = 7'h71;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_G     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {IDLE, PL, SEP1, PB, SEP2, SC, SEP3} state_t;

    // codes 0..9 are the decimal digits so a BCD nibble maps straight onto a glyph
    typedef enum logic [4:0] {
        G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
        G_P, G_L, G_C, G_J, G_U, G_G, G_E, G_B, G_DASH, G_BLANK
    } glyph_t;

    function automatic logic [6:0] seg_of(glyph_t g);
        case (g)
            G_0:     return SEG_0;
            G_1:     return SEG_1;
            G_2:     return SEG_2;
            G_3:     return SEG_3;
            G_4:     return SEG_4;
            G_5:     return SEG_5;
            G_6:     return SEG_6;
            G_7:     return SEG_7;
            G_8:     return SEG_8;
            G_9:     return SEG_9;
            G_P:     return SEG_P;
            G_L:     return SEG_L;
            G_C:     return SEG_C;
            G_J:     return SEG_J;
            G_U:     return SEG_U;
            G_G:     return SEG_G;
            G_E:     return SEG_E;
            G_B:     return SEG_B;
            G_DASH:  return SEG_DASH;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/judge_seq_tube_bin2bcd99.sv
// bin2bcd99: combinational 8-bit binary to two BCD digits, flags values above 99
module bin2bcd99 (
    input  logic [7:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       ovf
);

    assign ovf   = bin > 8'd99;
    assign tens  = 4'(bin / 8'd10);
    assign units = 4'(bin % 8'd10);

endmodule

// File: rtl/judge_seq_tube.sv
// judge_seq_tube: paged JUGE/PL/Pb/SC tube driver with handshake; JUDGE_TUBE_SEP_EN adds "----" separator pages
module judge_seq_tube import tube_pkg::*; #(
    parameter int DIGITS   = 8,
    parameter int CHANNELS = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DWELL    = 100000000,
    parameter int LOOP     = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          stop,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] player,
    input  logic [7:0]                                    problem_id,
    input  logic [7:0]                                    score,
    output logic                                          busy,
    output logic                                          done,
    output logic [7:0]                                    seg_out,
    output logic [DIGITS-1:0]                             seg_en
);

    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DWELL);
    localparam int IW = $clog2(DIGITS);

    state_t          state, nxt;
    logic            last, expire;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   pcnt;
    logic [IW-1:0]   idx;
    logic [3:0]      snap_pl;
    logic [7:0]      snap_pb, snap_sc;
    logic [3:0]      pb_t, pb_u, sc_t, sc_u;
    logic            pb_ovf, sc_ovf;
    glyph_t          g, hi, pl, pb, sc;

    bin2bcd99 u_pb (.bin(snap_pb), .tens(pb_t), .units(pb_u), .ovf(pb_ovf));
    bin2bcd99 u_sc (.bin(snap_sc), .tens(sc_t), .units(sc_u), .ovf(sc_ovf));

    assign expire = cnt == CW'(DWELL - 1);

    // page successor and end-of-pass detection
    always_comb begin
`ifdef JUDGE_TUBE_SEP_EN
        nxt  = state == PL ? SEP1 : state == SEP1 ? PB : state == PB ? SEP2 :
               state == SEP2 ? SC : state == SC ? SEP3 : (LOOP != 0 ? PL : IDLE);
        last = state == SEP3;
`else
        nxt  = state == PL ? PB : state == PB ? SC : (LOOP != 0 ? PL : IDLE);
        last = state == SC;
`endif
    end

    // sequencer: stop beats dwell expiry beats start; snapshot taken only on an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            snap_pl <= '0;
            snap_pb <= '0;
            snap_sc <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (state != IDLE && expire) begin
                state <= nxt;
                busy  <= nxt != IDLE;
                done  <= last;
                cnt   <= '0;
            end else if (state == IDLE && start && !stop) begin
                state   <= PL;
                busy    <= 1'b1;
                cnt     <= '0;
                snap_pl <= 4'(player) + 4'd1;
                snap_pb <= problem_id;
                snap_sc <= score;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // multiplex scan: prescaler wraps at SCAN_DIV, then the digit index steps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= pcnt == PW'(SCAN_DIV - 1) ? '0 : pcnt + 1'b1;
            if (pcnt == PW'(SCAN_DIV - 1))
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end

    // glyph for the digit currently being scanned
    always_comb begin
        hi = idx[1:0] == 2'd3 ? G_J : idx[1:0] == 2'd2 ? G_U : idx[1:0] == 2'd1 ? G_G : G_E;
        pl = idx[1:0] == 2'd3 ? G_P : idx[1:0] == 2'd2 ? G_L : idx[1:0] == 2'd1 ? G_0 :
             glyph_t'({1'b0, snap_pl});
        pb = idx[1:0] == 2'd3 ? G_P : idx[1:0] == 2'd2 ? G_B : pb_ovf ? G_DASH :
             idx[1:0] == 2'd1 ? glyph_t'({1'b0, pb_t}) : glyph_t'({1'b0, pb_u});
        sc = idx[1:0] == 2'd3 ? G_5 : idx[1:0] == 2'd2 ? G_C : sc_ovf ? G_DASH :
             idx[1:0] == 2'd1 ? glyph_t'({1'b0, sc_t}) : glyph_t'({1'b0, sc_u});
        g  = idx[2] ? hi : state == PL ? pl : state == PB ? pb : state == SC ? sc : G_DASH;
    end

    // registered tube pins, blank while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_en  <= '1;
            seg_out <= 8'hFF;
        end else begin
            seg_en  <= state == IDLE ? '1 : ~(DIGITS'(1) << idx);
            seg_out <= state == IDLE ? 8'hFF : {1'b1, seg_of(g)};
        end
    end

endmodule

// File: tb/tb_judge_seq_tube.sv
// tb_judge_seq_tube: table vectors, hand sequences and a timeline model for one-shot and loop instances
module tb_judge_seq_tube;

    localparam int SD = 2;
    localparam int DW = 20;
`ifdef JUDGE_TUBE_SEP_EN
    localparam int NP = 6, PBI = 2, SCI = 4;
`else
    localparam int NP = 3, PBI = 1, SCI = 2;
`endif
    localparam int P = NP * DW;

    logic       clk = 0, rst_n = 0, start = 0, stop = 0;
    logic [1:0] player = 0;
    logic [7:0] problem_id = 0, score = 0;
    logic       busy0, done0, busy1, done1;
    logic [7:0] seg0, seg1, en0, en1;

    judge_seq_tube #(.DIGITS(8), .CHANNELS(4), .SCAN_DIV(SD), .DWELL(DW), .LOOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .player(player),
        .problem_id(problem_id), .score(score), .busy(busy0), .done(done0),
        .seg_out(seg0), .seg_en(en0));

    judge_seq_tube #(.DIGITS(8), .CHANNELS(4), .SCAN_DIV(SD), .DWELL(DW), .LOOP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .player(player),
        .problem_id(problem_id), .score(score), .busy(busy1), .done(done1),
        .seg_out(seg1), .seg_en(en1));

    always #5 clk = ~clk;

    int cmp = 0, fails = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        cmp++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg7(byte c);
        logic [6:0] s;
        case (c)
            "0": s = 7'h40;  "1": s = 7'h79;  "2": s = 7'h24;  "3": s = 7'h30;
            "4": s = 7'h19;  "5": s = 7'h12;  "S": s = 7'h12;  "6": s = 7'h02;
            "7": s = 7'h78;  "8": s = 7'h00;  "9": s = 7'h10;  "P": s = 7'h0C;
            "L": s = 7'h47;  "C": s = 7'h46;  "J": s = 7'h71;  "U": s = 7'h41;
            "G": s = 7'h42;  "E": s = 7'h06;  "b": s = 7'h03;  "-": s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return {1'b1, s};
    endfunction

    function automatic string two(int v);
        return v > 99 ? "--" : $sformatf("%02d", v);
    endfunction

    // text of page p of a pass, built from the display rules
    function automatic string page_txt(int pl1, int pid, int sc, int p);
        string lo;
`ifdef JUDGE_TUBE_SEP_EN
        lo = p == 0 ? $sformatf("PL0%0d", pl1) : p == 2 ? {"Pb", two(pid)} :
             p == 4 ? {"SC", two(sc)} : "----";
`else
        lo = p == 0 ? $sformatf("PL0%0d", pl1) : p == 1 ? {"Pb", two(pid)} : {"SC", two(sc)};
`endif
        return {"JUGE", lo};
    endfunction

    // timeline model: a run starts at edge k, ends at edge e on stop, or after P edges when one-shot
    int   n = 0;
    bit   seen = 0;
    int   k[2] = '{-1, -1};
    int   e[2] = '{0, 0};
    int   spl[2], spid[2], ssc[2];
    bit   eb[2], ed[2];
    logic [7:0] een[2], eseg[2];

    function automatic bit act(int i, int j);
        return k[i] >= 0 && j >= k[i] && j < e[i] && (i == 1 || j - k[i] < P);
    endfunction

    always @(posedge clk) begin
        bit    ap;
        int    d;
        string s;
        seen = 1;
        if (!rst_n) begin
            n = 0;
            for (int i = 0; i < 2; i++) begin
                k[i] = -1; eb[i] = 0; ed[i] = 0; een[i] = 8'hFF; eseg[i] = 8'hFF;
            end
        end else begin
            n++;
            for (int i = 0; i < 2; i++) begin
                ap = act(i, n - 1);
                ed[i] = 0;
                if (ap && stop) e[i] = n;
                else if (ap) ed[i] = (n - k[i]) % P == 0;
                else if (start && !stop) begin
                    k[i] = n; e[i] = 32'h7fffffff;
                    spl[i] = int'(player) + 1; spid[i] = int'(problem_id); ssc[i] = int'(score);
                end
                eb[i] = act(i, n);
                if (ap) begin
                    d = ((n - 1) / SD) % 8;
                    s = page_txt(spl[i], spid[i], ssc[i], ((n - 1 - k[i]) / DW) % NP);
                    een[i] = ~(8'd1 << d);
                    eseg[i] = seg7(s[7 - d]);
                end else begin
                    een[i] = 8'hFF; eseg[i] = 8'hFF;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (seen) begin
            chk("m_busy0", busy0, eb[0]);  chk("m_done0", done0, ed[0]);
            chk("m_en0", en0, een[0]);     chk("m_seg0", seg0, eseg[0]);
            chk("m_busy1", busy1, eb[1]);  chk("m_done1", done1, ed[1]);
            chk("m_en1", en1, een[1]);     chk("m_seg1", seg1, eseg[1]);
        end
    end

    typedef struct {
        int    pl;
        int    pid;
        int    sc;
        string tpl;
        string tpb;
        string tsc;
    } vec_t;
    vec_t tv[4];

    function automatic string tbl_txt(int v, int p);
`ifdef JUDGE_TUBE_SEP_EN
        return p % 2 ? "JUGE----" : {"JUGE", p == 0 ? tv[v].tpl : p == 2 ? tv[v].tpb : tv[v].tsc};
`else
        return {"JUGE", p == 0 ? tv[v].tpl : p == 1 ? tv[v].tpb : tv[v].tsc};
`endif
    endfunction

    task automatic chk_text(string name, string txt);
        int  d = -1;
        byte c;
        for (int j = 0; j < 8; j++) if (en0 == ~(8'd1 << j)) d = j;
        chk({name, "_onehot"}, d >= 0, 1);
        if (d >= 0) begin
            c = txt[7 - d];
            chk(name, seg0, seg7(c));
        end
    endtask

    task automatic start_run(int pl, int pid, int sc);
        player = 2'(pl); problem_id = 8'(pid); score = 8'(sc);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 3 * P && busy0; c++) @(negedge clk);
        chk("idle_timeout", busy0, 0);
        @(negedge clk);
    endtask

    initial begin
        int c, bz, dn;
        tv[0] = '{2, 7,   45,  "PL03", "Pb07", "SC45"};
        tv[1] = '{2, 150, 99,  "PL03", "Pb--", "SC99"};
        tv[2] = '{0, 0,   100, "PL01", "Pb00", "SC--"};
        tv[3] = '{3, 99,  255, "PL04", "Pb99", "SC--"};

        rst_n = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_en", en0, 8'hFF); chk("rst_seg", seg0, 8'hFF); chk("rst_busy", busy0, 0);
        end
        rst_n = 1;
        @(negedge clk);
        chk("rel_en", en0, 8'hFF); chk("rel_seg", seg0, 8'hFF); chk("rel_busy", busy0, 0);

        for (int v = 0; v < 4; v++) begin
            start_run(tv[v].pl, tv[v].pid, tv[v].sc);
            chk("tbl_busy0", busy0, 1);
            for (int t = 1; t <= P + 1; t++) begin
                @(negedge clk);
                if (t <= P) chk_text("tbl_page", tbl_txt(v, (t - 1) / DW));
                else begin
                    chk("tbl_blank_en", en0, 8'hFF); chk("tbl_blank_seg", seg0, 8'hFF);
                end
                chk("tbl_done", done0, t == P);
                chk("tbl_busy", busy0, t < P);
            end
        end

        start_run(2, 7, 45);
        repeat (PBI * DW + 5) @(negedge clk);
        score = 12;
        repeat ((SCI - PBI) * DW - 3) @(negedge clk);
        repeat (8) begin
            @(negedge clk);
            chk_text("snap_sc", "JUGESC45");
        end
        wait_idle();

        start_run(1, 33, 66);
        repeat (PBI * DW + 5) @(negedge clk);
        stop = 1;
        @(posedge clk);
        @(negedge clk);
        stop = 0;
        chk("stop_busy", busy0, 0);
        @(negedge clk);
        chk("stop_blank_en", en0, 8'hFF); chk("stop_blank_seg", seg0, 8'hFF);
        dn = 0;
        repeat (2 * P) begin
            @(negedge clk);
            dn += int'(done0);
        end
        chk("stop_no_done", dn, 0);

        start = 1; stop = 1;
        @(negedge clk);
        start = 0; stop = 0;
        chk("start_stop_idle", busy0, 0);
        @(negedge clk);

        start_run(3, 20, 30);
        repeat (SCI * DW + 5) @(negedge clk);
        player = 0; problem_id = 1; score = 2; start = 1;
        @(negedge clk);
        start = 0;
        c = SCI * DW + 6;
        while (!done0 && c < 2 * P) begin
            @(negedge clk);
            c++;
        end
        chk("spur_len", c, P);
        wait_idle();

        for (int r = 0; r < 6; r++) begin
            start_run($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, P - 2)) @(negedge clk);
                stop = 1;
                @(negedge clk);
                stop = 0;
            end
            wait_idle();
        end

        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start_run(0, 5, 88);
        bz = 0;
        for (int p = 0; p < 3; p++) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
                if (!busy1) bz++;
            end while (!done1 && c < 2 * P);
            chk("loop_period", c, P);
        end
        chk("loop_busy", bz, 0);
        stop = 1;
        @(negedge clk);
        stop = 0;
        chk("loop_stop_busy", busy1, 0);
        chk("loop_stop_done", done1, 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule

// File: doc/judge_seq_tube.md
# judge_seq_tube

Parametrised successor of the judge-result tube driver: on a start pulse it snapshots player, problem ID and score, then steps an N-digit multiplexed 7-segment display through a fixed page sequence (JUGE/PLxx, Pbxx, SCxx) with a programmable dwell per page. It adds a start/busy/done handshake, one-shot or loop mode, an abort input, registered outputs and saturation of out-of-range values. It sits between the answering-machine judge controller and the board tube pins.

## Interface
- `DIGITS`, 8, number of tube digits; fixed layout needs exactly 8; index 7 is leftmost.
- `CHANNELS`, 4, number of players; legal range 1..9.
- `SCAN_DIV`, 100000, clocks per digit during the multiplex scan; minimum 1.
- `DWELL`, 100000000, clocks each page stays on; minimum 2.
- `LOOP`, 0; 0 runs the sequence once, 1 repeats it until `stop`.
- `clk` in 1: system clock.
- `rst_n` in 1: **synchronous, active-low reset**.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `stop` in 1: abort; returns to IDLE.
- `player` in $clog2(CHANNELS) (min 1): zero-based player index.
- `problem_id` in 8: problem number, binary.
- `score` in 8: score, binary.
- `busy` out 1: high while the sequence runs.
- `done` out 1: one-cycle pulse at the end of each pass.
- `seg_out` out 8: active-low segments; bit7 is dp and is always 1; bits 6:0 are g..a.
- `seg_en` out DIGITS: active-low one-hot digit enable.

## Operation
- FSM states: IDLE, PL, SEP1, PB, SEP2, SC, SEP3.
- In IDLE, `start` latches `player+1`, `problem_id` and `score` into snapshot registers and enters PL. Later input changes do not affect the display until the next start.
- Each page lasts exactly `DWELL` clocks, counted by a dwell counter that is cleared on every state entry.
- Pass order: PL, SEP1, PB, SEP2, SC, SEP3.
- At the end of SEP3:
  - LOOP=0: go to IDLE and pulse `done`.
  - LOOP=1: go to PL, pulse `done`, and keep the same snapshot.
- Digits 7..4 show "JUGE" in every non-IDLE state.
- Digits 3..0 per state:
  - PL: "PL0n", where n is the snapshot player digit.
  - PB: "Pb", then the tens and units of `problem_id`.
  - SC: "SC", then the tens and units of `score` (S uses the 5 glyph).
  - SEPx: "----".
- A value above 99 shows "--" in its two digit positions.
- In IDLE: `seg_en` is all ones and `seg_out` is 8'hFF.
- Priority, highest first: `rst_n` low, then `stop`, then dwell expiry, then `start`.
  - `stop` in any non-IDLE state: IDLE on the next clock, with no `done` pulse.
  - `start` while busy: ignored.
  - `start` and `stop` together in IDLE: stay in IDLE.

## Timing
- The scan prescaler counts 0..SCAN_DIV-1. At wrap, the digit index advances modulo DIGITS (7 wraps to 0). It runs in every state.
- `seg_en` and `seg_out` are registered. They reflect the digit index and state one clock after either changes.
- `start` sampled at edge k:
  - `busy`=1 from edge k.
  - PL content appears on the outputs from edge k+1.
- The last clock of SEP3 is edge m. On that edge:
  - `done`=1 for one clock.
  - LOOP=0: `busy`=0 on the same edge, and the outputs blank on edge m+1.
- Reset values: `busy`=0, `done`=0, `seg_en`=all ones, `seg_out`=8'hFF, state IDLE, all counters 0, snapshot 0.
- Reset asserted mid-sequence takes effect on the next edge with no `done` pulse.

## Configuration
- Macro `JUDGE_TUBE_SEP_EN`.
- Defined: the separator pages SEP1..SEP3 are present, so a pass is 6·DWELL clocks.
- Undefined: the separator states are compiled out; PL→PB→SC, then end of pass; a pass is 3·DWELL clocks, and `done` is timed from the end of SC.

## Structure
Package `tube_pkg`:
- Glyph localparams, 7-bit active-low g..a:
  - Digits 0..9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
  - Letters and symbols: P=0C, L=47, C=46, J=71, U=41, G=42, E=06, b=03, dash=3F, blank=7F.
- A state enum.
- A function mapping a glyph code to a segment pattern.

Sub-module `bin2bcd99`: combinational 8-bit to two BCD digits. It also outputs an overflow flag for values above 99; instantiate it twice.

## Test plan
Bench parameters: SCAN_DIV=2, DWELL=20, CHANNELS=4, LOOP=0, SEP enabled.
- **Reset:** hold `rst_n` low for 3 clocks → `seg_en`=FF, `seg_out`=FF, `busy`=0 throughout and after release.
- **One-shot pass:** `start` with player=2, problem_id=7, score=45 → sequence JUGE PL03 / ---- / Pb07 / ---- / SC45 / ----.
  - Each page lasts 20 clocks.
  - `done` pulses exactly once, 120 clocks after start.
  - `busy` falls with `done`.
- **Saturation:** problem_id=150, score=99 → "Pb--", then "SC99".
- **Snapshot:** change score from 45 to 12 during PB → the SC page still shows 45.
- **Stop and spurious start:** `stop` in PB → blank on the next clock and no `done`; `start` during SC is ignored, and the pass length is unchanged.
- **Loop mode:** LOOP=1 → `done` pulses every 120 clocks and `busy` stays 1. `stop` then ends the sequence. With `JUDGE_TUBE_SEP_EN` undefined, the pass is 60 clocks.
